// File: rtl/mod_share_pkg.sv
// mod_share_pkg: shared state encoding, default width and sizing helpers for mod_share_arbiter.
package mod_share_pkg;
  localparam int DEF_DATA_W = 32;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CLEAR = 2'd1;
  localparam state_t RUN   = 2'd2;
  localparam state_t RESP  = 2'd3;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int wd_w(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/mod_share_arbiter_if.sv
// mod_share_arbiter_if: requester handshake plus modulo-unit link; slave = arbiter, master = requesters/unit.
interface mod_share_arbiter_if import mod_share_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0]         rsp_result, mu_a, mu_b, mu_result;
  logic                      rsp_err, busy, mu_clr, mu_start, mu_done;
  modport slave (
    input  req_valid, req_a, req_b, mu_result, mu_done,
    output req_ready, rsp_valid, rsp_result, rsp_err, busy, mu_clr, mu_start, mu_a, mu_b
  );
  modport master (
    output req_valid, req_a, req_b, mu_result, mu_done,
    input  req_ready, rsp_valid, rsp_result, rsp_err, busy, mu_clr, mu_start, mu_a, mu_b
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  // Scan farthest-first so the candidate closest to ptr overwrites the rest.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) idx = IW'((int'(ptr) + i) % NUM_REQ);
  end
  assign any   = |req;
  assign grant = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/mod_share_arbiter.sv
// mod_share_arbiter: round-robin sharing of one iterative modulo unit with settle window and watchdog.
// Define MOD_DIVZERO_GUARD_EN to answer b==0 locally (result=a, err=1) without touching the unit.
module mod_share_arbiter import mod_share_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MU_SETTLE = 2,
  parameter int TIMEOUT   = 4096
) (
  input logic clk,
  input logic rst_n,
  mod_share_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int WW = wd_w(TIMEOUT);
`ifdef MOD_DIVZERO_GUARD_EN
  localparam bit DZ_GUARD = 1'b1;
`else
  localparam bit DZ_GUARD = 1'b0;
`endif
  state_t              state;
  logic [IW-1:0]       ptr, idx, pick;
  logic [NUM_REQ-1:0]  grant;
  logic                any, dz, fin_done, fin_to;
  logic [WW-1:0]       wd;
  logic [DATA_W-1:0]   a_sel, b_sel;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(pick), .any(any)
  );
  assign a_sel    = bus.req_a[int'(pick)*DATA_W +: DATA_W];
  assign b_sel    = bus.req_b[int'(pick)*DATA_W +: DATA_W];
  assign dz       = DZ_GUARD && b_sel == '0;
  // A done seen inside the settle window may be left over from the previous operation.
  assign fin_done = wd >= WW'(MU_SETTLE) && bus.mu_done;
  assign fin_to   = wd == WW'(TIMEOUT - 1);
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      wd             <= '0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      bus.mu_clr     <= 1'b0;
      bus.mu_start   <= 1'b0;
      bus.mu_a       <= '0;
      bus.mu_b       <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.mu_clr    <= 1'b0;
      case (state)
        IDLE: if (any) begin
          idx           <= pick;
          bus.mu_a      <= a_sel;
          bus.mu_b      <= b_sel;
          bus.req_ready <= grant;
          if (dz) begin
            state          <= RESP;
            bus.rsp_valid  <= grant;
            bus.rsp_result <= a_sel;
            bus.rsp_err    <= 1'b1;
          end else begin
            state      <= CLEAR;
            bus.mu_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state        <= RUN;
          bus.mu_start <= 1'b1;
          wd           <= '0;
        end
        RUN: begin
          wd <= wd + 1'b1;
          if (fin_done || fin_to) begin
            state          <= RESP;
            bus.mu_start   <= 1'b0;
            bus.rsp_valid  <= NUM_REQ'(1) << idx;
            bus.rsp_result <= fin_done ? bus.mu_result : '0;
            bus.rsp_err    <= !fin_done;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
      endcase
    end
  end
endmodule
